hamming_decoder: RTL and testbench

Hardware SECDED decoder for the 16-bit Hamming codewords our encoder program writes to data memory. On a `start` pulse it walks NUM_WORDS codeword byte pairs in data memory and writes each decoded 11-bit word back with a 2-bit error flag. Single-bit errors are corrected and double-bit errors are flagged. It masters the byte-wide data memory port while busy and sits beside the core as a memory-mapped accelerator.

---
 rtl/hamming_decoder.sv | 178 +++++++++++++++++
 tb/tb_hamming_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// SECDED decoder for 16-bit Hamming codewords held in byte-wide data memory.
// Optional saturating error counters enabled by HAMMING_DEC_STATS_EN.
module hamming_decoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned SRC_BASE  = 0,
  parameter int unsigned DST_BASE  = 30,
  parameter int unsigned NUM_WORDS = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        sec_count,
  output logic [7:0]        ded_count
);

  localparam int unsigned KW =
    (NUM_WORDS > 0) ? $clog2(NUM_WORDS + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, CAP, DEC, WR_LO, WR_HI, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    hi_q, hi_d;
  logic [10:0]   data_q, data_d;
  logic [1:0]    flag_q, flag_d;

  logic [15:0]   cw, cw_fix;
  logic [3:0]    syn;
  logic          par;
  logic [10:0]   dec_data;
  logic [1:0]    dec_flag;
  logic [31:0]   k_ext;
  logic          last;
  logic          go;

  // Syndrome is the XOR of the indices of all set bits.
  always_comb begin
    cw  = {hi_q, lo_q};
    syn = '0;
    for (int i = 1; i < 16; i++) begin
      if (cw[i]) syn = syn ^ 4'(i);
    end
    par    = ^cw;
    cw_fix = cw;
    if (par) cw_fix[syn] = ~cw[syn];
    dec_data = {cw_fix[15:9], cw_fix[7:5], cw_fix[3]};
    if (par)
      dec_flag = 2'b01;
    else if (syn != 4'd0)
      dec_flag = 2'b10;
    else
      dec_flag = 2'b00;
  end

  assign k_ext = 32'(k_q);
  assign last  = (k_ext + 32'd1) == NUM_WORDS;
  assign go    = start &&
                 (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    data_d    = data_q;
    flag_d    = flag_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          k_d     = '0;
          state_d = (NUM_WORDS == 0) ? DONE : RD_LO;
        end
      end
      RD_LO: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(SRC_BASE + 32'd2 * k_ext);
        state_d   = RD_HI;
      end
      RD_HI: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  =
          ADDR_W'(SRC_BASE + 32'd2 * k_ext + 32'd1);
        lo_d      = mem_rdata;
        state_d   = CAP;
      end
      CAP: begin
        busy    = 1'b1;
        hi_d    = mem_rdata;
        state_d = DEC;
      end
      DEC: begin
        busy    = 1'b1;
        data_d  = dec_data;
        flag_d  = dec_flag;
        state_d = WR_LO;
      end
      WR_LO: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = ADDR_W'(DST_BASE + 32'd2 * k_ext);
        mem_wdata = data_q[7:0];
        state_d   = WR_HI;
      end
      WR_HI: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  =
          ADDR_W'(DST_BASE + 32'd2 * k_ext + 32'd1);
        mem_wdata = {flag_q, 3'b000, data_q[10:8]};
        k_d       = k_q + KW'(1);
        state_d   = last ? DONE : RD_LO;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  logic [7:0] sec_q, ded_q;

  always_ff @(posedge clk) begin
    if (reset || go) begin
      sec_q <= '0;
      ded_q <= '0;
    end else if (state_q == DEC) begin
      if (dec_flag == 2'b01 && sec_q != 8'hFF)
        sec_q <= sec_q + 8'd1;
      if (dec_flag == 2'b10 && ded_q != 8'hFF)
        ded_q <= ded_q + 8'd1;
    end
  end

  assign sec_count = sec_q;
  assign ded_count = ded_q;
`else
  logic unused_go;
  assign unused_go = go;
  assign sec_count = '0;
  assign ded_count = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: one 15-word instance
// and one zero-word instance sharing clock and reset.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start0;
  logic       busy, done, busy0, done0;
  logic [7:0] addr, addr0;
  logic       rd, wr, rd0, wr0;
  logic [7:0] rdata, rdata0;
  logic [7:0] wdata, wdata0;
  logic [7:0] sec, ded, sec0, ded0;

  logic [7:0] mem [0:255];
  int n_rd, n_wr, n_both, n_acc0;
  int n_chk = 0;
  int n_err = 0;

  logic [15:0] cw_t [15];
  logic [7:0]  lo_t [15];
  logic [7:0]  hi_t [15];

  always #5 clk = ~clk;

  assign rdata0 = 8'h00;

  hamming_decoder #(.NUM_WORDS(15)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .mem_addr(addr), .mem_rd_en(rd),
    .mem_rdata(rdata), .mem_wr_en(wr),
    .mem_wdata(wdata),
    .sec_count(sec), .ded_count(ded)
  );

  hamming_decoder #(.NUM_WORDS(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .busy(busy0), .done(done0),
    .mem_addr(addr0), .mem_rd_en(rd0),
    .mem_rdata(rdata0), .mem_wr_en(wr0),
    .mem_wdata(wdata0),
    .sec_count(sec0), .ded_count(ded0)
  );

  always @(posedge clk) begin
    if (rd) rdata <= mem[addr];
    if (wr) mem[addr] <= wdata;
    if (rd) n_rd <= n_rd + 1;
    if (wr) n_wr <= n_wr + 1;
    if (rd && wr) n_both <= n_both + 1;
    if (rd0 || wr0) n_acc0 <= n_acc0 + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  initial begin
    int lat;
    int bad;
    int exp_sec, exp_ded;
    logic found;

    cw_t = '{16'h0000, 16'hFFFF, 16'hFFDF, 16'hFFFE,
             16'hFDDF, 16'h000F, 16'h100F, 16'h0009,
             16'h010F, 16'h7FFF, 16'hFFFC, 16'h0001,
             16'h0008, 16'h0028, 16'h8000};
    lo_t = '{8'h00, 8'hFF, 8'hFF, 8'hFF,
             8'hED, 8'h01, 8'h01, 8'h01,
             8'h01, 8'hFF, 8'hFF, 8'h00,
             8'h00, 8'h03, 8'h00};
    hi_t = '{8'h00, 8'h07, 8'h47, 8'h47,
             8'h87, 8'h00, 8'h40, 8'h80,
             8'h40, 8'h47, 8'h87, 8'h40,
             8'h40, 8'h80, 8'h40};
`ifdef HAMMING_DEC_STATS_EN
    exp_sec = 8;
    exp_ded = 4;
`else
    exp_sec = 0;
    exp_ded = 0;
`endif

    reset  = 1'b1;
    start  = 1'b0;
    start0 = 1'b0;
    n_rd = 0; n_wr = 0; n_both = 0; n_acc0 = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hAA;
    for (int k = 0; k < 15; k++) begin
      mem[2*k]   = cw_t[k][7:0];
      mem[2*k+1] = cw_t[k][15:8];
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_sec", 32'(sec), 0);
    chk("rst_ded", 32'(ded), 0);
    chk("rst_done0", 32'(done0), 0);
    @(negedge clk);
    reset = 1'b0;

    // Full run with a stray start pulse while busy.
    @(negedge clk);
    n_rd = 0; n_wr = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    lat = 0;
    while (!done && lat < 200) begin
      start = (lat == 20);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk("done_lat_15", lat, 90);
    chk("busy_at_done", 32'(busy), 0);
    chk("reads", n_rd, 30);
    chk("writes", n_wr, 30);
    chk("rd_wr_overlap", n_both, 0);
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("lo_w%0d", k),
          32'(mem[30+2*k]), 32'(lo_t[k]));
      chk($sformatf("hi_w%0d", k),
          32'(mem[31+2*k]), 32'(hi_t[k]));
    end
    chk("sec_count", 32'(sec), 32'(exp_sec));
    chk("ded_count", 32'(ded), 32'(exp_ded));
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", 32'(done), 1);

    // Restart from DONE, then reset in WR_LO of word 3.
    for (int i = 30; i < 60; i++) mem[i] = 8'hAA;
    @(negedge clk);
    n_wr = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_drop", 32'(done), 0);
    found = 1'b0;
    lat = 0;
    while (!found && lat < 200) begin
      if (wr && addr == 8'd36) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    chk("reach_wrlo3", 32'(found), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_wr", 32'(wr), 0);
    chk("mid_rst_rd", 32'(rd), 0);
    chk("mid_rst_sec", 32'(sec), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_writes", n_wr, 7);
    chk("kept_w2_lo", 32'(mem[34]), 32'h FF);
    chk("kept_w2_hi", 32'(mem[35]), 32'h47);
    chk("kept_w3_lo", 32'(mem[36]), 32'hFF);
    bad = 0;
    for (int i = 37; i < 60; i++)
      if (mem[i] != 8'hAA) bad++;
    chk("no_write_after_rst", bad, 0);
    chk("idle_done", 32'(done), 0);

    // Zero-word instance goes straight to DONE.
    @(negedge clk);
    n_acc0 = 0;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_lat_0", lat, 0);
    chk("busy0", 32'(busy0), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("acc0", n_acc0, 0);
    chk("addr0", 32'(addr0), 0);
    chk("wdata0", 32'(wdata0), 0);
    chk("cnt0", 32'({sec0, ded0}), 0);
    chk("done0_held", 32'(done0), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
